// File: rtl/frame_buffer_pingpong.sv
// -----------------------------------------------------------------------------
// frame_buffer_pingpong
//
// Double-buffered (ping-pong) frame store between a camera capture stream and
// a VGA-style (x,y) readout, all on one clock. The writer fills the back bank
// while the reader scans the front bank. Banks swap only at a reader frame
// boundary (rd_vsync) and only when the back bank holds a complete frame, so
// the displayed image never tears. Read latency is one cycle.
//
// Optional feature macro: FB_SCALE2X_EN
//   defined   : rd_x/rd_y span 2*H_RES x 2*V_RES and are halved before lookup
//               (pixel doubling, e.g. a 320x240 store shown on 640x480).
//   undefined : rd_x/rd_y address the store directly.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous reset, active-low
//   wr_sof       start-of-frame; marks the first pixel when wr_valid=1
//   wr_valid     writer pixel strobe
//   wr_data      writer pixel data
//   rd_vsync     reader frame-boundary pulse (swap opportunity)
//   rd_en        read request
//   rd_x, rd_y   read column / row
//   rd_data      read pixel, one cycle after rd_en (0 when out of range)
//   rd_valid     rd_data qualifier
//   front_sel    bank currently displayed
//   frame_ready  complete frame waiting in the back bank
//   frame_drop   one-cycle pulse: a waiting frame was discarded by a new wr_sof
// -----------------------------------------------------------------------------
module frame_buffer_pingpong #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int DATA_W = 12,
`ifdef FB_SCALE2X_EN
  localparam int S     = 1,
`else
  localparam int S     = 0,
`endif
  localparam int DEPTH = H_RES * V_RES,
  localparam int A_W   = $clog2(DEPTH),
  localparam int X_W   = $clog2(H_RES) + S,
  localparam int Y_W   = $clog2(V_RES) + S
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_sof,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_vsync,
  input  logic              rd_en,
  input  logic [X_W-1:0]    rd_x,
  input  logic [Y_W-1:0]    rd_y,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              front_sel,
  output logic              frame_ready,
  output logic              frame_drop
);

  localparam logic [A_W-1:0] LAST_ADDR  = A_W'(DEPTH - 1);
  localparam logic [A_W:0]   BANK1_BASE = (A_W + 1)'(DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_t;

  // Two banks packed back to back: bank 1 starts at DEPTH, so storage is
  // exactly 2*DEPTH words even when DEPTH is not a power of two.
  logic [DATA_W-1:0] mem [2*DEPTH];

  function automatic logic [A_W:0] bank_idx(input logic bank, input logic [A_W-1:0] addr);
    return (bank ? BANK1_BASE : '0) + {1'b0, addr};
  endfunction

  wr_state_t      state_q, state_d;
  logic [A_W-1:0] wr_addr_q, wr_addr_d;
  logic [A_W-1:0] mem_waddr;
  logic           mem_we;
  logic           last_px;
  logic           sof_acc;
  logic           swap;

  assign sof_acc = wr_sof & wr_valid;

  // A pending frame is promoted only while the writer is idle and not starting
  // a new frame; this also keeps a last-pixel/vsync collision from swapping,
  // because frame_ready is still low in that cycle.
  assign swap = rd_vsync & frame_ready & (state_q == ST_IDLE) & ~sof_acc;

  // Writer FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Writer FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sof_acc) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (sof_acc)                                  state_d = ST_WRITE;
        else if (wr_valid && wr_addr_q == LAST_ADDR)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Writer FSM: outputs (memory write strobe, address, frame completion)
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr_q;
    wr_addr_d = wr_addr_q;
    last_px   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Pixels without a start-of-frame are dropped here.
        if (sof_acc) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wr_addr_d = A_W'(1);
        end
      end
      ST_WRITE: begin
        if (sof_acc) begin
          // Restart: the aborted frame is simply overwritten.
          mem_we    = 1'b1;
          mem_waddr = '0;
          wr_addr_d = A_W'(1);
        end else if (wr_valid) begin
          mem_we = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            last_px   = 1'b1;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + A_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Frame bookkeeping and bank selection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_q   <= '0;
      front_sel   <= 1'b0;
      frame_ready <= 1'b0;
      frame_drop  <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      front_sel  <= front_sel ^ swap;
      frame_drop <= sof_acc & frame_ready;
      if (sof_acc)      frame_ready <= 1'b0;
      else if (last_px) frame_ready <= 1'b1;
      else if (swap)    frame_ready <= 1'b0;
    end
  end

  // The writer always targets the bank not on display.
  always_ff @(posedge clk) begin
    if (mem_we) mem[bank_idx(~front_sel, mem_waddr)] <= wr_data;
  end

  // ---- read stage p0: coordinate scaling, range check, linear address ----
  logic [X_W-1:0] rx_p0;
  logic [Y_W-1:0] ry_p0;
  logic           in_range_p0;
  logic [A_W-1:0] rd_lin_p0;

  always_comb begin
`ifdef FB_SCALE2X_EN
    rx_p0 = rd_x >> 1;
    ry_p0 = rd_y >> 1;
`else
    rx_p0 = rd_x;
    ry_p0 = rd_y;
`endif
  end

  assign in_range_p0 = (32'(rx_p0) < 32'(H_RES)) && (32'(ry_p0) < 32'(V_RES));
  // Truncation only matters for out-of-range coordinates, whose result is
  // masked by in_range_p0.
  assign rd_lin_p0   = A_W'(32'(ry_p0) * 32'(H_RES) + 32'(rx_p0));

  // ---- read stage p1: registered pixel; holds when no request ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= in_range_p0 ? mem[bank_idx(front_sel, rd_lin_p0)] : '0;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// -----------------------------------------------------------------------------
// Bench for frame_buffer_pingpong. Uses a 5x3 store so that out-of-range
// columns and rows are reachable through the port widths and the bank layout
// is exercised with a non-power-of-two depth. Pixel (x,y) of a frame written
// as base+i lives at i = y*5 + x, so pixel (1,1) is base+6.
// -----------------------------------------------------------------------------
module tb_frame_buffer_pingpong;

  localparam int H     = 5;
  localparam int V     = 3;
  localparam int DW    = 12;
  localparam int DEPTH = H * V;
`ifdef FB_SCALE2X_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif
  localparam int XW = $clog2(H) + S;
  localparam int YW = $clog2(V) + S;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          wr_sof   = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data  = '0;
  logic          rd_vsync = 1'b0;
  logic          rd_en    = 1'b0;
  logic [XW-1:0] rd_x     = '0;
  logic [YW-1:0] rd_y     = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          front_sel;
  logic          frame_ready;
  logic          frame_drop;

  frame_buffer_pingpong #(.H_RES(H), .V_RES(V), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_sof     (wr_sof),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .rd_vsync   (rd_vsync),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .front_sel  (front_sel),
    .frame_ready(frame_ready),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Two frame arrays, the displayed index, and a count of pixels received
  // for the frame in progress (-1 when no frame is being received).
  int m_pix   [2][DEPTH];
  bit m_known [2][DEPTH];
  int m_front = 0;
  bit m_ready = 1'b0;
  bit m_drop  = 1'b0;
  int m_count = -1;
  bit m_rv    = 1'b0;
  int m_rd    = 0;
  bit m_rdk   = 1'b1;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_front = 0; m_ready = 1'b0; m_drop = 1'b0; m_count = -1;
        m_rv = 1'b0; m_rd = 0; m_rdk = 1'b1;
      end else begin
        bit acc, old_ready, receiving;
        int rx, ry, back;
        acc       = wr_sof && wr_valid;
        old_ready = m_ready;
        receiving = (m_count >= 0);
        back      = 1 - m_front;
        // reader sees the bank displayed before this edge
        if (rd_en) begin
          rx   = int'(rd_x) / (1 << S);
          ry   = int'(rd_y) / (1 << S);
          m_rv = 1'b1;
          if (rx >= H || ry >= V) begin
            m_rd = 0; m_rdk = 1'b1;
          end else begin
            m_rd  = m_pix[m_front][ry*H + rx];
            m_rdk = m_known[m_front][ry*H + rx];
          end
        end else begin
          m_rv = 1'b0;
        end
        m_drop = acc && old_ready;
        if (acc) begin
          m_pix[back][0] = int'(wr_data); m_known[back][0] = 1'b1;
          m_count = 1; m_ready = 1'b0;
        end else if (wr_valid && receiving) begin
          m_pix[back][m_count] = int'(wr_data); m_known[back][m_count] = 1'b1;
          m_count++;
          if (m_count == DEPTH) begin
            m_count = -1; m_ready = 1'b1;
          end
        end
        if (rd_vsync && old_ready && !receiving && !acc) begin
          m_front = 1 - m_front; m_ready = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("front_sel",   32'(front_sel),   32'(m_front));
      check("frame_ready", 32'(frame_ready), 32'(m_ready));
      check("frame_drop",  32'(frame_drop),  32'(m_drop));
      check("rd_valid",    32'(rd_valid),    32'(m_rv));
      if (m_rdk) check("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  // ---------------- stimulus ----------------
  function automatic int px(input int c);
    return c * (1 << S);
  endfunction

  // Apply one cycle of inputs (called at a negedge; returns at the next one).
  task automatic drive(input bit sof, input bit v, input int d, input bit vs,
                       input bit en, input int x, input int y);
    wr_sof   = sof;
    wr_valid = v;
    wr_data  = DW'(d);
    rd_vsync = vs;
    rd_en    = en;
    rd_x     = XW'(x);
    rd_y     = YW'(y);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // partial frame, then asynchronous reset in the middle of it
    drive(1, 1, 'h0AA, 0, 0, 0, 0);
    drive(0, 1, 'h0AB, 0, 0, 0, 0);
    drive(0, 1, 'h0AC, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    check("rst_front_sel",   32'(front_sel),   32'd0);
    check("rst_frame_ready", 32'(frame_ready), 32'd0);
    check("rst_frame_drop",  32'(frame_drop),  32'd0);
    check("rst_rd_valid",    32'(rd_valid),    32'd0);
    check("rst_rd_data",     32'(rd_data),     32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("post_rst_ready", 32'(frame_ready), 32'd0);

    // frame A: 0x100..0x10E into bank 1
    for (int i = 0; i < DEPTH; i++) drive(i == 0, 1, 'h100 + i, 0, 0, 0, 0);
    check("A_ready", 32'(frame_ready), 32'd1);
    check("A_front", 32'(front_sel),   32'd0);
    // stray pixels without start-of-frame while idle
    drive(0, 1, 'hFFF, 0, 0, 0, 0);
    drive(0, 1, 'hFFE, 0, 0, 0, 0);
    check("stray_ready", 32'(frame_ready), 32'd1);
    drive(0, 0, 0, 1, 0, 0, 0);
    check("swap_front", 32'(front_sel),   32'd1);
    check("swap_ready", 32'(frame_ready), 32'd0);
    drive(0, 0, 0, 0, 1, px(1), px(1));
    check("rd11_valid", 32'(rd_valid), 32'd1);
    check("rd11_data",  32'(rd_data),  32'h106);
`ifdef FB_SCALE2X_EN
    drive(0, 0, 0, 0, 1, px(1) + 1, px(1) + 1);
    check("rd33_data", 32'(rd_data), 32'h106);
`endif
    drive(0, 0, 0, 0, 1, px(0), px(0));
    check("rd00_data", 32'(rd_data), 32'h100);
    drive(0, 0, 0, 0, 1, px(4), px(2));
    check("rd42_data", 32'(rd_data), 32'h10E);
    drive(0, 0, 0, 0, 1, px(5), px(0));
    check("oor_x_valid", 32'(rd_valid), 32'd1);
    check("oor_x_data",  32'(rd_data),  32'd0);
    drive(0, 0, 0, 0, 1, px(2), px(3));
    check("oor_y_data",  32'(rd_data),  32'd0);
    drive(0, 0, 0, 0, 1, px(3), px(0));
    drive(0, 0, 0, 0, 0, px(1), px(1));
    check("hold_valid", 32'(rd_valid), 32'd0);
    check("hold_data",  32'(rd_data),  32'h103);

    // frame B completes, then a new sof discards it
    for (int i = 0; i < DEPTH; i++) drive(i == 0, 1, 'h200 + i, 0, 0, 0, 0);
    check("B_ready", 32'(frame_ready), 32'd1);
    drive(1, 1, 'h300, 0, 0, 0, 0);
    check("drop_pulse", 32'(frame_drop),  32'd1);
    check("drop_ready", 32'(frame_ready), 32'd0);
    drive(0, 1, 'h301, 1, 0, 0, 0);
    check("drop_noswap", 32'(front_sel),  32'd1);
    check("drop_once",   32'(frame_drop), 32'd0);
    for (int i = 2; i < DEPTH - 1; i++) drive(0, 1, 'h300 + i, 0, 0, 0, 0);
    // last pixel coincides with vsync: no swap yet
    drive(0, 1, 'h30E, 1, 0, 0, 0);
    check("coll_front", 32'(front_sel),   32'd1);
    check("coll_ready", 32'(frame_ready), 32'd1);
    drive(0, 0, 0, 1, 0, 0, 0);
    check("late_swap", 32'(front_sel), 32'd0);
    drive(0, 0, 0, 0, 1, px(1), px(1));
    check("C_rd11", 32'(rd_data), 32'h306);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      drive(($urandom % 40) == 0, ($urandom % 10) < 7, int'($urandom % (1 << DW)),
            ($urandom % 25) == 0, $urandom % 2,
            int'($urandom % (1 << XW)), int'($urandom % (1 << YW)));
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
